// File: rtl/xif_issue_queue_if.sv
// Signal bundle between the CORE-V-XIF issue/commit side and the FPU dispatch side
// of xif_issue_queue. The master drives issue, commit, flush and dispatch_ready.
interface xif_issue_queue_if #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int INSTR_WIDTH = 32
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                   flush;
    logic                   issue_valid;
    logic                   issue_ready;
    logic                   issue_accept;
    logic [INSTR_WIDTH-1:0] issue_instr;
    logic [X_ID_WIDTH-1:0]  issue_id;
    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;
    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic [INSTR_WIDTH-1:0] dispatch_instr;
    logic [X_ID_WIDTH-1:0]  dispatch_id;
    logic [CNT_WIDTH-1:0]   occupancy;
    logic                   empty;
    logic                   full;

    modport master (
        output flush, issue_valid, issue_accept, issue_instr, issue_id,
               commit_valid, commit_id, commit_kill, dispatch_ready,
        input  issue_ready, dispatch_valid, dispatch_instr, dispatch_id,
               occupancy, empty, full
    );

    modport slave (
        input  flush, issue_valid, issue_accept, issue_instr, issue_id,
               commit_valid, commit_id, commit_kill, dispatch_ready,
        output issue_ready, dispatch_valid, dispatch_instr, dispatch_id,
               occupancy, empty, full
    );
endinterface

// File: rtl/xif_issue_queue.sv
// In-order issue queue between XIF issue/commit and the FPU pipeline: holds accepted
// instructions, records commit/kill per entry, dispatches committed heads, drops killed ones.
module xif_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int INSTR_WIDTH = 32
) (
    input  logic             ck,
    input  logic             rst_n,
    xif_issue_queue_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       committed_q;
    logic [DEPTH-1:0]       killed_q;
    logic [X_ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [CNT_WIDTH-1:0]   count;

    logic full_w;
    logic issue_ready_w;
    logic head_valid;
    logic dispatch_valid_w;
    logic auto_pop;
    logic pop;
    logic enq;

    assign full_w           = (count == CNT_WIDTH'(DEPTH));
    assign issue_ready_w    = !full_w && rst_n;
    assign head_valid       = valid_q[rd_ptr];
    assign dispatch_valid_w = head_valid && committed_q[rd_ptr] && !killed_q[rd_ptr];
    assign auto_pop         = head_valid && killed_q[rd_ptr];
    assign pop              = (dispatch_valid_w && bus.dispatch_ready) || auto_pop;
    assign enq              = bus.issue_valid && issue_ready_w && bus.issue_accept;

    // Scan entries in age order starting at the head; slot k is k places behind it.
    logic [PTR_WIDTH-1:0] scan_idx [DEPTH];
    logic [DEPTH-1:0]     match_age;

    for (genvar k = 0; k < DEPTH; k++) begin : g_scan
        assign scan_idx[k]  = rd_ptr + PTR_WIDTH'(k);
        assign match_age[k] = valid_q[scan_idx[k]] && !committed_q[scan_idx[k]]
                              && !killed_q[scan_idx[k]] && (id_q[scan_idx[k]] == bus.commit_id);
    end

    logic                 hit;
    logic [PTR_WIDTH-1:0] hit_idx;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_age[k]) begin
                hit     = 1'b1;
                hit_idx = scan_idx[k];
            end
        end
    end

    logic commit_hit;
    logic commit_new;

    assign commit_hit = bus.commit_valid && hit;
    // With no older match, a commit naming the instruction being enqueued lands on the new entry.
    assign commit_new = bus.commit_valid && !hit && (bus.commit_id == bus.issue_id);

    // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            // NOTE: payload storage is reset too, so the head outputs read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (bus.flush) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr]     <= 1'b0;
                committed_q[rd_ptr] <= 1'b0;
                killed_q[rd_ptr]    <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_WIDTH'(1);
            end
            if (commit_hit) begin
                if (bus.commit_kill) killed_q[hit_idx]    <= 1'b1;
                else                 committed_q[hit_idx] <= 1'b1;
            end
            if (enq) begin
                valid_q[wr_ptr]     <= 1'b1;
                committed_q[wr_ptr] <= commit_new && !bus.commit_kill;
                killed_q[wr_ptr]    <= commit_new && bus.commit_kill;
                id_q[wr_ptr]        <= bus.issue_id;
                instr_q[wr_ptr]     <= bus.issue_instr;
                wr_ptr              <= wr_ptr + PTR_WIDTH'(1);
            end
            count <= count + CNT_WIDTH'(enq) - CNT_WIDTH'(pop);
        end
    end

    assign bus.issue_ready    = issue_ready_w;
    assign bus.dispatch_valid = dispatch_valid_w;
    assign bus.dispatch_instr = instr_q[rd_ptr];
    assign bus.dispatch_id    = id_q[rd_ptr];
    assign bus.occupancy      = count;
    assign bus.empty          = (count == '0);
    assign bus.full           = full_w;
endmodule

// File: tb/tb_xif_issue_queue.sv
// Self-checking bench for xif_issue_queue: a queue-of-entries reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_xif_issue_queue;
    localparam int DEPTH = 4;
    localparam int XW    = 4;
    localparam int IW    = 32;

    logic ck;
    logic rst_n;
    int   checks;
    int   errors;

    xif_issue_queue_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .INSTR_WIDTH(IW)) bus ();

    xif_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .INSTR_WIDTH(IW)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] instr_of(input logic [XW-1:0] id);
        return 32'hF00D_0000 | IW'(id) | (IW'(id) << 8);
    endfunction

    // Reference model: an age-ordered list of in-flight instructions.
    typedef struct {
        logic [XW-1:0] id;
        logic [IW-1:0] instr;
        bit            c;
        bit            k;
    } ent_t;

    ent_t m_q[$];
    bit   m_hit;
    bit   m_pop;
    bit   m_room;
    bit   m_dv;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
        end else if (bus.flush) begin
            m_q.delete();
        end else begin
            m_room = (m_q.size() < DEPTH);
            m_pop  = (m_q.size() > 0) && (m_q[0].k || (m_q[0].c && bus.dispatch_ready));
            m_hit  = 1'b0;
            if (bus.commit_valid) begin
                foreach (m_q[i]) begin
                    if (!m_hit && m_q[i].id == bus.commit_id && !m_q[i].c && !m_q[i].k) begin
                        m_hit = 1'b1;
                        if (bus.commit_kill) m_q[i].k = 1'b1;
                        else                 m_q[i].c = 1'b1;
                    end
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (bus.issue_valid && bus.issue_accept && m_room) begin
                ent_t e;
                e.id    = bus.issue_id;
                e.instr = bus.issue_instr;
                e.c     = bus.commit_valid && !m_hit && bus.commit_id == bus.issue_id && !bus.commit_kill;
                e.k     = bus.commit_valid && !m_hit && bus.commit_id == bus.issue_id && bus.commit_kill;
                m_q.push_back(e);
            end
        end
    end

    always @(posedge ck) begin
        #1;
        if (rst_n) begin
            m_dv = (m_q.size() > 0) && m_q[0].c && !m_q[0].k;
            check("model.occupancy", 64'(bus.occupancy), 64'(m_q.size()));
            check("model.empty", 64'(bus.empty), 64'(m_q.size() == 0));
            check("model.full", 64'(bus.full), 64'(m_q.size() == DEPTH));
            check("model.issue_ready", 64'(bus.issue_ready), 64'(m_q.size() < DEPTH));
            check("model.dispatch_valid", 64'(bus.dispatch_valid), 64'(m_dv));
            if (m_dv) begin
                check("model.dispatch_id", 64'(bus.dispatch_id), 64'(m_q[0].id));
                check("model.dispatch_instr", 64'(bus.dispatch_instr), 64'(m_q[0].instr));
            end
        end
    end

    task automatic idle();
        bus.flush        = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_accept = 1'b0;
        bus.issue_instr  = '0;
        bus.issue_id     = '0;
        bus.commit_valid = 1'b0;
        bus.commit_id    = '0;
        bus.commit_kill  = 1'b0;
    endtask

    task automatic issue(input logic [XW-1:0] id);
        bus.issue_valid  = 1'b1;
        bus.issue_accept = 1'b1;
        bus.issue_id     = id;
        bus.issue_instr  = instr_of(id);
    endtask

    task automatic commit(input logic [XW-1:0] id, input bit kill);
        bus.commit_valid = 1'b1;
        bus.commit_id    = id;
        bus.commit_kill  = kill;
    endtask

    task automatic cyc();
        @(posedge ck);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".issue_ready"}, 64'(bus.issue_ready), 64'd0);
        check({tag, ".dispatch_valid"}, 64'(bus.dispatch_valid), 64'd0);
        check({tag, ".empty"}, 64'(bus.empty), 64'd1);
        check({tag, ".full"}, 64'(bus.full), 64'd0);
        check({tag, ".occupancy"}, 64'(bus.occupancy), 64'd0);
        check({tag, ".dispatch_id"}, 64'(bus.dispatch_id), 64'd0);
        check({tag, ".dispatch_instr"}, 64'(bus.dispatch_instr), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        bus.dispatch_ready = 1'b0;
        repeat (2) @(posedge ck);
        #2;
        check_reset_outputs("reset");
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        check("post_reset.issue_ready", 64'(bus.issue_ready), 64'd1);

        // In-order commit and dispatch of 1,2,3.
        bus.dispatch_ready = 1'b1;
        issue(4'd1); cyc();
        issue(4'd2); cyc();
        issue(4'd3); cyc();
        check("seq.occ3", 64'(bus.occupancy), 64'd3);
        idle(); commit(4'd1, 1'b0); cyc();
        check("seq.dv1", 64'(bus.dispatch_valid), 64'd1);
        check("seq.id1", 64'(bus.dispatch_id), 64'd1);
        idle(); commit(4'd2, 1'b0); cyc();
        check("seq.id2", 64'(bus.dispatch_id), 64'd2);
        check("seq.occ2", 64'(bus.occupancy), 64'd2);
        idle(); commit(4'd3, 1'b0); cyc();
        check("seq.id3", 64'(bus.dispatch_id), 64'd3);
        check("seq.occ1", 64'(bus.occupancy), 64'd1);
        idle(); cyc();
        check("seq.occ0", 64'(bus.occupancy), 64'd0);
        check("seq.empty", 64'(bus.empty), 64'd1);

        // Fill to DEPTH, refuse a fifth, then steady enqueue/dispatch across the wrap.
        bus.dispatch_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idle(); issue(4'(i)); cyc();
        end
        check("full.occ", 64'(bus.occupancy), 64'd4);
        check("full.full", 64'(bus.full), 64'd1);
        check("full.issue_ready", 64'(bus.issue_ready), 64'd0);
        idle(); issue(4'd5); cyc();
        check("full.no_fifth", 64'(bus.occupancy), 64'd4);
        idle(); commit(4'd1, 1'b0); cyc();
        check("full.head_dv", 64'(bus.dispatch_valid), 64'd1);
        check("full.still_not_ready", 64'(bus.issue_ready), 64'd0);
        idle(); bus.dispatch_ready = 1'b1; cyc();
        check("full.ready_after_pop", 64'(bus.issue_ready), 64'd1);
        check("full.occ_after_pop", 64'(bus.occupancy), 64'd3);
        idle(); commit(4'd2, 1'b0); cyc();
        for (int i = 0; i < 8; i++) begin
            check("wrap.dispatch_id", 64'(bus.dispatch_id), 64'(2 + i));
            idle(); issue(4'(5 + i)); commit(4'(3 + i), 1'b0); cyc();
            check("wrap.occ", 64'(bus.occupancy), 64'd3);
        end
        check("wrap.last_id", 64'(bus.dispatch_id), 64'd10);
        idle(); commit(4'd11, 1'b0); cyc();
        idle(); commit(4'd12, 1'b0); cyc();
        check("wrap.id12", 64'(bus.dispatch_id), 64'd12);
        idle(); cyc();
        check("wrap.drained", 64'(bus.occupancy), 64'd0);

        // Two killed heads auto-pop on consecutive cycles, then 7 dispatches.
        for (int i = 5; i <= 7; i++) begin
            idle(); issue(4'(i)); cyc();
        end
        idle(); commit(4'd5, 1'b1); cyc();
        check("kill.dv_a", 64'(bus.dispatch_valid), 64'd0);
        check("kill.occ_a", 64'(bus.occupancy), 64'd3);
        idle(); commit(4'd6, 1'b1); cyc();
        check("kill.dv_b", 64'(bus.dispatch_valid), 64'd0);
        check("kill.occ_b", 64'(bus.occupancy), 64'd2);
        idle(); commit(4'd7, 1'b0); cyc();
        check("kill.dv_c", 64'(bus.dispatch_valid), 64'd1);
        check("kill.id7", 64'(bus.dispatch_id), 64'd7);
        check("kill.occ_c", 64'(bus.occupancy), 64'd1);
        idle(); cyc();
        check("kill.drained", 64'(bus.occupancy), 64'd0);

        // Commit arriving in the enqueue cycle.
        bus.dispatch_ready = 1'b0;
        idle(); issue(4'd9); commit(4'd9, 1'b0); cyc();
        check("same.dv", 64'(bus.dispatch_valid), 64'd1);
        check("same.id9", 64'(bus.dispatch_id), 64'd9);
        check("same.instr9", 64'(bus.dispatch_instr), 64'(instr_of(4'd9)));
        idle(); cyc();
        check("same.hold_id", 64'(bus.dispatch_id), 64'd9);
        bus.dispatch_ready = 1'b1; cyc();
        check("same.drained", 64'(bus.occupancy), 64'd0);

        // Unaccepted issue, unknown-ID commit, then a killed single entry.
        bus.dispatch_ready = 1'b0;
        idle(); issue(4'd4); cyc();
        idle(); issue(4'd3); bus.issue_accept = 1'b0; cyc();
        check("noacc.occ", 64'(bus.occupancy), 64'd1);
        idle(); commit(4'd12, 1'b0); cyc();
        check("unknown.occ", 64'(bus.occupancy), 64'd1);
        check("unknown.dv", 64'(bus.dispatch_valid), 64'd0);
        idle(); commit(4'd4, 1'b1); cyc();
        check("kill1.dv", 64'(bus.dispatch_valid), 64'd0);
        idle(); cyc();
        check("kill1.occ", 64'(bus.occupancy), 64'd0);

        // Duplicate IDs: a commit marks only the oldest uncommitted match.
        idle(); issue(4'd2); cyc();
        idle(); issue(4'd2); cyc();
        idle(); commit(4'd2, 1'b0); cyc();
        check("dup.dv", 64'(bus.dispatch_valid), 64'd1);
        check("dup.occ2", 64'(bus.occupancy), 64'd2);
        bus.dispatch_ready = 1'b1;
        idle(); commit(4'd2, 1'b0); cyc();
        check("dup.dv_second", 64'(bus.dispatch_valid), 64'd1);
        check("dup.occ1", 64'(bus.occupancy), 64'd1);
        idle(); cyc();
        check("dup.occ0", 64'(bus.occupancy), 64'd0);

        // Flush beats a simultaneous enqueue and dispatch.
        bus.dispatch_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle(); issue(4'(i)); cyc();
        end
        idle(); commit(4'd1, 1'b0); cyc();
        check("flush.pre_dv", 64'(bus.dispatch_valid), 64'd1);
        idle(); issue(4'd4); bus.flush = 1'b1; bus.dispatch_ready = 1'b1; cyc();
        check("flush.occ", 64'(bus.occupancy), 64'd0);
        check("flush.empty", 64'(bus.empty), 64'd1);
        check("flush.dv", 64'(bus.dispatch_valid), 64'd0);
        idle(); bus.dispatch_ready = 1'b0; commit(4'd4, 1'b0); cyc();
        check("flush.gone_occ", 64'(bus.occupancy), 64'd0);
        check("flush.gone_dv", 64'(bus.dispatch_valid), 64'd0);

        // Asynchronous reset in the middle of traffic.
        idle(); issue(4'd1); cyc();
        idle(); issue(4'd2); commit(4'd1, 1'b0); cyc();
        idle();
        check("midrst.pre_dv", 64'(bus.dispatch_valid), 64'd1);
        check("midrst.pre_occ", 64'(bus.occupancy), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        check("midrst.ready", 64'(bus.issue_ready), 64'd1);
        check("midrst.occ", 64'(bus.occupancy), 64'd0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
